dct_block_sequencer: RTL and testbench
======================================

Name: dct_block_sequencer

Overview:
- Streams 8x8 pixel blocks in as 64 serial 32-bit words and presents each block in parallel to the DCT_2D array.
- Waits the array's fixed pipeline latency, captures the 64 coefficients and streams them out serially, in row-major or zigzag order.
- Sits between the pixel source and the quantiser.
- Double-buffered: the next block may load while the previous block's coefficients drain.

Parameters:
- DCT_LATENCY, 10: aclk cycles from a stable dct_in to a valid dct_out (DCT_2D pipeline depth). Legal range 1..255.
- ZIGZAG, 1: 1 = emit coefficients in JPEG zigzag order; 0 = emit in row-major index order.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- s_tdata  in  32  input pixel word
- s_tvalid  in  1  input word valid
- s_tready  out  1  sequencer accepts a word
- s_tlast  in  1  source marks word 63 of a block
- m_tdata  out  32  output coefficient
- m_tvalid  out  1  output valid
- m_tready  in  1  sink accepts
- m_tlast  out  1  marks coefficient 63 of a block
- dct_in  out  2048  word k (bits 32k+31:32k) drives DCT_2D input I{r}{c}, with r=k/8 and c=k%8
- dct_out  in  2048  word k is DCT_2D output O{r}{c}, same indexing
- err_frame  out  1  one-cycle pulse on s_tlast mismatch
- busy  out  1  high when any block is in flight (either side non-idle)

Behaviour:
- Fixed interface decisions: one clock, aclk. Reset areset is synchronous and active-high.
- Reset values:
  - s_tready=0, m_tvalid=0, m_tlast=0, err_frame=0, busy=0, dct_in=all zeros.
  - Both FSMs return to their first state and all counters clear.
  - Reset mid-block discards all partial and buffered data.
  - s_tready becomes 1 in the first cycle after areset deasserts.
- Input FSM states: LOAD, WAIT, CAPTURE.
  - LOAD: s_tready=1. On each s_tvalid&s_tready, store s_tdata into input buffer word wr_idx, then wr_idx++.
  - On the accept with wr_idx==63, go to WAIT and clear the latency counter.
  - The input buffer drives dct_in directly and stays stable through WAIT.
  - WAIT: s_tready=0. The counter increments every cycle.
  - When count==DCT_LATENCY-1 and the output buffer is empty, go to CAPTURE. Otherwise stay in WAIT, with the counter saturating.
  - CAPTURE (one cycle): copy all 64 words of dct_out into the output buffer, mark the output buffer full, clear wr_idx, go to LOAD.
  - End-to-end minimum latency, last input accept to first m_tvalid: DCT_LATENCY+2 cycles.
- s_tlast check:
  - If s_tlast=1 on an accept with wr_idx!=63, or s_tlast=0 on the accept with wr_idx==63, pulse err_frame on the next cycle.
  - Framing is always by count, never by s_tlast.
- Output FSM states: EMPTY, SEND.
  - In SEND, m_tvalid=1 and m_tdata = output buffer word ORDER[rd_idx].
  - ORDER is the zigzag table if ZIGZAG=1, otherwise the identity.
  - rd_idx advances on m_tvalid&m_tready. m_tlast=1 when rd_idx==63.
  - The accept with rd_idx==63 goes to EMPTY and clears the full flag.
- Simultaneous events:
  - CAPTURE may not coincide with SEND. The full flag clears in the same cycle as the final accept, so CAPTURE can occur at the earliest in the next cycle.
  - m_tdata and m_tvalid hold stable while m_tready=0 (AXI-Stream rules). No combinational path from m_tready to m_tvalid.
  - Backpressure: while the output buffer is full, WAIT stalls, so the input stalls at most one block behind.
- Arithmetic: data is passed through untouched. Counters are 6-bit and wrap only via the explicit clears.

Decomposition:
- Package dct_pkg holds:
  - BLK_WORDS=64, WORD_W=32.
  - The 64-entry zigzag constant table ZZ_ORDER (0,1,8,16,9,2,3,10,17,24,...,63).
  - State enums for both FSMs.
- One natural sub-module: dct_coef_unloader (output buffer plus output FSM plus ordering).
- The top instantiates the unloader and holds the input side.

Test Plan:
- Bench stub replaces DCT_2D: dct_out word k = dct_in word k + 0x1000, delayed DCT_LATENCY cycles.
- Test 1: ZIGZAG=0. Stream words 0..63 with values 0..63, m_tready=1 → m_tdata = 0x1000..0x103F in order. m_tlast on the 64th beat only. First m_tvalid exactly DCT_LATENCY+2 cycles after the last input accept.
- Test 2: ZIGZAG=1, same input → output sequence starts 0x1000, 0x1001, 0x1008, 0x1010, 0x1009, 0x1002 and ends 0x103F.
- Test 3: two back-to-back blocks with m_tready=0 for 200 cycles → s_tready=0 after block 2 loads. Block 1 is output intact and block 2 follows with no loss. busy stays 1 throughout.
- Test 4: random s_tvalid/m_tready toggling over 4 blocks → outputs match the scoreboard and m_tdata is stable while stalled.
- Test 5: s_tlast asserted on word 10 → err_frame=1 for exactly one cycle. The block still completes after 64 words with correct data.
- Test 6: areset pulsed after 30 words loaded → all outputs return to reset values. The next full block is processed correctly with no stale words.

Source files
------------

// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dct_pkg
// Description : Shared constants, zigzag scan table and FSM state types for
//               the DCT block sequencer and its coefficient unloader.
// Revision    : 1.0 - initial release
// ============================================================================
package dct_pkg;

    localparam int BLK_WORDS = 64;
    localparam int WORD_W    = 32;
    localparam int BLK_W     = BLK_WORDS * WORD_W;

    // JPEG zigzag scan: entry n is the row-major index of the n-th coefficient
    localparam logic [5:0] ZZ_ORDER [BLK_WORDS] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Input side: fill the buffer, wait out the array latency, grab results
    typedef enum logic [1:0] {
        IN_LOAD    = 2'd0,
        IN_WAIT    = 2'd1,
        IN_CAPTURE = 2'd2
    } in_state_t;

    // Output side: nothing buffered / draining the coefficient buffer
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_SEND  = 1'b1
    } out_state_t;

    // Map an output beat number to the buffer word it should carry
    function automatic logic [5:0] coef_order(input logic [5:0] idx, input bit zigzag);
        return zigzag ? ZZ_ORDER[idx] : idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct_block_sequencer_unloader.sv
`default_nettype none
// ============================================================================
// Module      : dct_coef_unloader
// Description : Output coefficient buffer for one 8x8 block plus the stream
//               FSM that drains it in row-major or zigzag order.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_coef_unloader
    import dct_pkg::*;
#(
    parameter int ZIGZAG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [BLK_W-1:0]  coef_in,
    output logic              full,
    output logic [WORD_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    localparam bit ZZ = (ZIGZAG != 0);

    logic [WORD_W-1:0] coef_buf [BLK_WORDS];
    out_state_t        state;
    logic [5:0]        rd_idx;
    logic [5:0]        next_idx;

    assign next_idx = rd_idx + 6'd1;

    // Snapshot the whole array output in the single capture cycle
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < BLK_WORDS; k++) begin
                coef_buf[k] <= coef_in[k*WORD_W +: WORD_W];
            end
        end
    end

    // Drain FSM; m_tdata is pre-fetched one beat ahead so every output is a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OUT_EMPTY;
            full     <= 1'b0;
            rd_idx   <= 6'd0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
        end else begin
            // The input side only captures while the buffer is free, so this
            // never collides with the clear on the final beat below.
            if (capture) begin
                full <= 1'b1;
            end
            case (state)
                OUT_EMPTY: begin
                    if (full) begin
                        state    <= OUT_SEND;
                        rd_idx   <= 6'd0;
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b0;
                        m_tdata  <= coef_buf[coef_order(6'd0, ZZ)];
                    end
                end
                OUT_SEND: begin
                    if (m_tready) begin
                        if (rd_idx == 6'd63) begin
                            state    <= OUT_EMPTY;
                            full     <= 1'b0;
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                        end else begin
                            rd_idx  <= next_idx;
                            m_tdata <= coef_buf[coef_order(next_idx, ZZ)];
                            m_tlast <= (next_idx == 6'd63);
                        end
                    end
                end
                default: begin
                    state <= OUT_EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dct_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dct_block_sequencer
// Description : Loads 64 serial pixel words into a parallel block for the
//               DCT_2D array, waits out its pipeline latency, captures the 64
//               coefficients and hands them to the serial unloader. The input
//               buffer refills while the previous block drains.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_block_sequencer
    import dct_pkg::*;
#(
    parameter int DCT_LATENCY = 10,
    parameter int ZIGZAG      = 1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [WORD_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output logic [WORD_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [BLK_W-1:0]  dct_in,
    input  logic [BLK_W-1:0]  dct_out,
    output logic              err_frame,
    output logic              busy
);

    // Latency counter is 8 bits so the full 1..255 range fits
    localparam logic [7:0] LAT_LAST = 8'(DCT_LATENCY - 1);

    in_state_t  in_state;
    logic [5:0] wr_idx;
    logic [7:0] lat_cnt;
    logic       out_full;
    logic       capture;
    logic       accept;
    logic       last_word;

    assign accept    = s_tvalid & s_tready;
    assign last_word = (wr_idx == 6'd63);
    assign capture   = (in_state == IN_CAPTURE);

    // Either side holding data counts as a block in flight
    assign busy = (in_state != IN_LOAD) || (wr_idx != 6'd0) || out_full;

    // Input buffer doubles as the array input bus; it only changes in LOAD
    always_ff @(posedge aclk) begin
        if (areset) begin
            dct_in <= '0;
        end else if (accept) begin
            dct_in[{wr_idx, 5'b00000} +: WORD_W] <= s_tdata;
        end
    end

    // Input FSM: count words in, wait for the array and a free output buffer
    always_ff @(posedge aclk) begin
        if (areset) begin
            in_state  <= IN_LOAD;
            s_tready  <= 1'b0;
            wr_idx    <= 6'd0;
            lat_cnt   <= 8'd0;
            err_frame <= 1'b0;
        end else begin
            // Framing is by count; s_tlast is only checked, never obeyed
            err_frame <= accept && (s_tlast != last_word);
            case (in_state)
                IN_LOAD: begin
                    s_tready <= 1'b1;
                    if (accept) begin
                        if (last_word) begin
                            in_state <= IN_WAIT;
                            lat_cnt  <= 8'd0;
                            s_tready <= 1'b0;
                        end else begin
                            wr_idx <= wr_idx + 6'd1;
                        end
                    end
                end
                IN_WAIT: begin
                    // Counter parks at the limit while the output side is full
                    if (lat_cnt == LAT_LAST) begin
                        if (!out_full) begin
                            in_state <= IN_CAPTURE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                IN_CAPTURE: begin
                    wr_idx   <= 6'd0;
                    in_state <= IN_LOAD;
                    s_tready <= 1'b1;
                end
                default: begin
                    in_state <= IN_LOAD;
                    s_tready <= 1'b0;
                end
            endcase
        end
    end

    dct_coef_unloader #(
        .ZIGZAG   (ZIGZAG)
    ) u_unloader (
        .clk      (aclk),
        .rst      (areset),
        .capture  (capture),
        .coef_in  (dct_out),
        .full     (out_full),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast)
    );

endmodule
`default_nettype wire

// File: tb/tb_dct_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_block_sequencer
// Description : Two sequencers (row-major and zigzag) share one stimulus
//               stream; each has its own DCT_2D stand-in (word + 0x1000,
//               delayed LAT cycles). A block-level model of accepted pixels
//               predicts every output beat, flag and first-beat latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_block_sequencer;

    localparam int LAT = 10;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        areset   = 1'b1;
    logic [31:0] s_tdata  = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast  = 1'b0;
    logic        m_tready = 1'b1;
    int          rdy_mode = 0;   // 0 ready, 1 stalled, 2 random

    logic [1:0][31:0]   m_tdata_a;
    logic [1:0]         m_tvalid_a, m_tlast_a, s_tready_a, err_a, busy_a;
    logic [1:0][2047:0] dct_in_a, dct_out_a;

    function automatic logic [2047:0] add_bias(input logic [2047:0] d);
        logic [2047:0] r;
        for (int k = 0; k < 64; k++) r[k*32 +: 32] = d[k*32 +: 32] + 32'h1000;
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [2047:0] pipe [LAT];
        dct_block_sequencer #(.DCT_LATENCY(LAT), .ZIGZAG(g)) u_dut (
            .aclk(aclk), .areset(areset),
            .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready_a[g]), .s_tlast(s_tlast),
            .m_tdata(m_tdata_a[g]), .m_tvalid(m_tvalid_a[g]), .m_tready(m_tready), .m_tlast(m_tlast_a[g]),
            .dct_in(dct_in_a[g]), .dct_out(dct_out_a[g]),
            .err_frame(err_a[g]), .busy(busy_a[g])
        );
        always @(posedge aclk) begin
            pipe[0] <= add_bias(dct_in_a[g]);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign dct_out_a[g] = pipe[LAT-1];
    end

    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'b0;
            default: m_tready = ($urandom_range(99) < 55);
        endcase
    end

    // Zigzag scan derived by walking the anti-diagonals of the 8x8 grid
    function automatic int zz_at(input int j);
        int n, lo, hi;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin
                    if (n == j) return r * 8 + (s - r);
                    n++;
                end
            end else begin
                for (int r = hi; r >= lo; r--) begin
                    if (n == j) return r * 8 + (s - r);
                    n++;
                end
            end
        end
        return 0;
    endfunction

    function automatic int ord(input int g, input int j);
        return (g == 0) ? j : zz_at(j);
    endfunction

    // ---------------- scoreboard / monitor state ----------------
    int          checks = 0, failures = 0;
    logic [31:0] blocks [$];          // accepted pixels, 64 per complete block
    int          pos [2] = '{0, 0};   // beats consumed per instance
    int          in_cnt = 0;
    logic [31:0] cur [64];
    bit          err_next = 0, rst_q = 0, rst_q2 = 0;
    bit          stall_q [2] = '{0, 0};
    logic [31:0] hold_d [2];
    bit          hold_l [2];
    bit          prev_valid [2] = '{0, 0};
    bit          arm [2] = '{0, 0};
    int          arm_cyc [2] = '{0, 0};
    int          cyc = 0;
    bit          drain_req = 0, drain_ack = 0;
    int          drain_timer = 0;
    int          stim_tmo = 0, stim_tmo_seen = 0;

    task automatic chk(input string name, input int g, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst%0d actual=0x%0h required=0x%0h t=%0t", name, g, act, exp, $time);
        end
    endtask

    always @(negedge aclk) begin
        int j, b;
        logic [31:0] expd;
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (rst_q) begin
                chk("rst_s_tready", g, s_tready_a[g], 0);
                chk("rst_m_tvalid", g, m_tvalid_a[g], 0);
                chk("rst_m_tlast", g, m_tlast_a[g], 0);
                chk("rst_err_frame", g, err_a[g], 0);
                chk("rst_busy", g, busy_a[g], 0);
                chk("rst_dct_in_zero", g, longint'(dct_in_a[g] == '0), 1);
            end else begin
                chk("err_frame", g, err_a[g], err_next);
                chk("busy", g, busy_a[g], longint'((in_cnt != 0) || (pos[g] < blocks.size())));
                if (rst_q2) chk("s_tready_after_reset", g, s_tready_a[g], 1);
                if (blocks.size() - pos[g] > 64) chk("s_tready_backpressure", g, s_tready_a[g], 0);
                if (stall_q[g]) begin
                    chk("hold_m_tvalid", g, m_tvalid_a[g], 1);
                    chk("hold_m_tdata", g, m_tdata_a[g], hold_d[g]);
                    chk("hold_m_tlast", g, m_tlast_a[g], hold_l[g]);
                end
                // valid rises after edge A+LAT+2, seen at the negedge LAT+3 after the one preceding A
                if (m_tvalid_a[g] && !prev_valid[g] && arm[g]) begin
                    chk("first_valid_latency", g, cyc - arm_cyc[g], LAT + 3);
                    arm[g] = 0;
                end
                if (m_tvalid_a[g] && pos[g] >= blocks.size()) chk("spurious_m_tvalid", g, 1, 0);
            end
            if (!areset && m_tvalid_a[g] && m_tready && pos[g] < blocks.size()) begin
                j = pos[g] % 64;
                b = pos[g] / 64;
                expd = blocks[b * 64 + ord(g, j)] + 32'h1000;
                chk("m_tdata", g, m_tdata_a[g], expd);
                chk("m_tlast", g, m_tlast_a[g], longint'(j == 63));
                pos[g]++;
            end
            stall_q[g]    = !areset && m_tvalid_a[g] && !m_tready;
            hold_d[g]     = m_tdata_a[g];
            hold_l[g]     = m_tlast_a[g];
            prev_valid[g] = m_tvalid_a[g];
        end

        if (areset) begin
            blocks.delete();
            pos      = '{0, 0};
            arm      = '{0, 0};
            in_cnt   = 0;
            err_next = 0;
        end else begin
            err_next = 0;
            if (s_tvalid && s_tready_a[0]) begin
                err_next    = (s_tlast != (in_cnt == 63));
                cur[in_cnt] = s_tdata;
                in_cnt++;
                if (in_cnt == 64) begin
                    for (int g = 0; g < 2; g++) begin
                        if (pos[g] == blocks.size()) begin
                            arm[g]     = 1;
                            arm_cyc[g] = cyc;
                        end
                    end
                    for (int k = 0; k < 64; k++) blocks.push_back(cur[k]);
                    in_cnt = 0;
                end
            end
        end

        if (drain_req && !drain_ack) begin
            if (pos[0] == blocks.size() && pos[1] == blocks.size() && in_cnt == 0) begin
                checks++;
                drain_ack = 1;
            end else if (++drain_timer > 5000) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout pending0=%0d pending1=%0d required=0", blocks.size() - pos[0], blocks.size() - pos[1]);
                drain_ack = 1;
            end
        end else if (!drain_req) begin
            drain_ack   = 0;
            drain_timer = 0;
        end

        if (stim_tmo != stim_tmo_seen) begin
            checks++;
            failures++;
            $display("FAIL s_tready_timeout actual=no_accept required=accept");
            stim_tmo_seen = stim_tmo;
        end

        rst_q2 = rst_q;
        rst_q  = areset;
    end

    // ---------------- stimulus ----------------
    task automatic send_block(input int nwords, input bit ramp, input int err_word, input int gap_pct);
        bit acc;
        int tmo;
        for (int k = 0; k < nwords; k++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_tvalid = 1'b0;
                @(posedge aclk); #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = ramp ? 32'(k) : $urandom;
            s_tlast  = (k == 63) || (k == err_word);
            acc = 0;
            tmo = 0;
            while (!acc) begin
                @(negedge aclk);
                acc = s_tready_a[0];
                @(posedge aclk); #1;
                if (!acc && ++tmo > 3000) begin
                    stim_tmo++;
                    s_tvalid = 1'b0;
                    s_tlast  = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        drain_req = 1;
        wait (drain_ack);
        drain_req = 0;
        wait (!drain_ack);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    initial begin
        repeat (4) @(posedge aclk);
        #1 areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // Ramp block: row-major on instance 0, zigzag on instance 1, sink always ready
        rdy_mode = 0;
        send_block(64, 1, -1, 0);
        wait_drain();

        // Two blocks back-to-back against a stalled sink
        rdy_mode = 1;
        send_block(64, 0, -1, 0);
        send_block(64, 0, -1, 0);
        repeat (200) @(posedge aclk);
        #1 rdy_mode = 0;
        wait_drain();

        // Random gaps and random backpressure over four blocks
        rdy_mode = 2;
        for (int n = 0; n < 4; n++) send_block(64, 0, -1, 30);
        wait_drain();
        rdy_mode = 0;

        // Early s_tlast on word 10
        send_block(64, 0, 10, 0);
        wait_drain();

        // Reset after 30 words, then a clean block
        send_block(30, 0, -1, 0);
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        send_block(64, 0, -1, 10);
        wait_drain();

        repeat (5) @(posedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
